// File: rtl/r5p_mouse_soc_reset_ctrl_if.sv
// Reset request / status bundle between the board-side requesters and the SoC reset sequencer.
interface r5p_mouse_soc_reset_ctrl_if;
  logic       btn_i;
  logic       sw_req;
  logic       soc_rst;
  logic [1:0] rst_cause;
  logic [7:0] rst_cnt;

  modport master (
    output btn_i,
    output sw_req,
    input  soc_rst,
    input  rst_cause,
    input  rst_cnt
  );

  modport slave (
    input  btn_i,
    input  sw_req,
    output soc_rst,
    output rst_cause,
    output rst_cnt
  );
endinterface

// File: rtl/r5p_mouse_soc_reset_ctrl.sv
// SoC reset sequencer: merges POR, debounced button and software requests into one
// minimum-length synchronous reset, and records the last cause plus a saturating count.
//
// state    | meaning
// HOLD     | soc_rst high, hold counter running down to release
// WAIT_REL | soc_rst high until the debounced button is released
// RUN      | soc_rst low, SoC running
module r5p_mouse_soc_reset_ctrl #(
  parameter int unsigned SYNC_FF  = 2,
  parameter int unsigned DEB_CNT  = 270000,
  parameter int unsigned HOLD_CNT = 16,
  parameter logic        BTN_ACT  = 1'b1
) (
  input logic                        clk,
  input logic                        rst,
  r5p_mouse_soc_reset_ctrl_if.slave  bus
);

  localparam int unsigned DW = $clog2(DEB_CNT + 1);
  localparam int unsigned HW = $clog2(HOLD_CNT + 1);

  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CNT);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CNT);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_BTN = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    WAIT_REL = 2'd1,
    RUN      = 2'd2
  } state_t;

  logic              btn_pressed;
  logic [SYNC_FF-1:0] sync_q;
  logic              sync_lvl;
  logic              deb_lvl;
  logic [DW-1:0]     deb_cnt;
  logic              deb_flip;
  logic              press_flip;
  logic              release_flip;

  state_t            state;
  logic [HW-1:0]     hold_cnt;
  logic              soc_rst_q;
  logic [1:0]        cause_q;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_inc;

  // Normalise polarity so 1 always means pressed downstream.
  assign btn_pressed = bus.btn_i ^ ~BTN_ACT;
  assign sync_lvl    = sync_q[SYNC_FF-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_FF-2:0], btn_pressed};
    end
  end

  assign deb_flip     = (sync_lvl != deb_lvl) && (deb_cnt == DEB_MAX);
  assign press_flip   = deb_flip && sync_lvl;
  assign release_flip = deb_flip && !sync_lvl;

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_lvl <= 1'b0;
      deb_cnt <= '0;
    end else if (deb_flip) begin
      deb_lvl <= sync_lvl;
      deb_cnt <= '0;
    end else if (sync_lvl != deb_lvl) begin
      deb_cnt <= deb_cnt + DW'(1);
    end else begin
      deb_cnt <= '0;
    end
  end

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // soc_rst is registered alongside the state so it always equals (state != RUN).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      hold_cnt  <= HOLD_LD;
      soc_rst_q <= 1'b1;
      cause_q   <= CAUSE_POR;
      cnt_q     <= 8'd0;
    end else begin
      case (state)
        HOLD: begin
          hold_cnt <= hold_cnt - HOLD_ONE;
          if (press_flip) begin
            state     <= WAIT_REL;
            cause_q   <= CAUSE_BTN;
            soc_rst_q <= 1'b1;
          end else if (hold_cnt == HOLD_ONE) begin
            state     <= RUN;
            soc_rst_q <= 1'b0;
          end else begin
            soc_rst_q <= 1'b1;
          end
        end
        WAIT_REL: begin
          soc_rst_q <= 1'b1;
          if (release_flip) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LD;
          end
        end
        RUN: begin
          if (press_flip) begin
            state     <= WAIT_REL;
            cause_q   <= CAUSE_BTN;
            cnt_q     <= cnt_inc;
            soc_rst_q <= 1'b1;
          end else if (bus.sw_req) begin
            state     <= HOLD;
            hold_cnt  <= HOLD_LD;
            cause_q   <= CAUSE_SW;
            cnt_q     <= cnt_inc;
            soc_rst_q <= 1'b1;
          end else begin
            soc_rst_q <= 1'b0;
          end
        end
        default: begin
          state     <= HOLD;
          hold_cnt  <= HOLD_LD;
          soc_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.soc_rst   = soc_rst_q;
  assign bus.rst_cause = cause_q;
  assign bus.rst_cnt   = cnt_q;

endmodule

// File: tb/tb_r5p_mouse_soc_reset_ctrl.sv
// Directed bench for the SoC reset sequencer with SYNC_FF=2, DEB_CNT=4, HOLD_CNT=3.
module tb_r5p_mouse_soc_reset_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  r5p_mouse_soc_reset_ctrl_if bus ();

  r5p_mouse_soc_reset_ctrl #(
    .SYNC_FF (2),
    .DEB_CNT (4),
    .HOLD_CNT(3),
    .BTN_ACT (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_cnt;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.btn_i = 1'b0;
    bus.sw_req = 1'b0;

    // POR: rst high for 5 edges, then 3 more high cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("por_hold_rst", 32'(bus.soc_rst), 32'd1);
    end
    check("por_cause", 32'(bus.rst_cause), 32'd0);
    check("por_cnt", 32'(bus.rst_cnt), 32'd0);
    rst = 1'b0;
    tick(); check("por_after1", 32'(bus.soc_rst), 32'd1);
    tick(); check("por_after2", 32'(bus.soc_rst), 32'd1);
    tick(); check("por_release", 32'(bus.soc_rst), 32'd0);
    check("por_cause_run", 32'(bus.rst_cause), 32'd0);
    check("por_cnt_run", 32'(bus.rst_cnt), 32'd0);

    // Glitch: 3-cycle press is filtered out
    bus.btn_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check("glitch_on", 32'(bus.soc_rst), 32'd0);
    end
    bus.btn_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); check("glitch_off", 32'(bus.soc_rst), 32'd0);
    end
    check("glitch_cnt", 32'(bus.rst_cnt), 32'd0);
    check("glitch_cause", 32'(bus.rst_cause), 32'd0);

    // Press: soc_rst rises on the 7th edge sampling the press
    bus.btn_i = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(); check("press_lat", 32'(bus.soc_rst), 32'd0);
    end
    tick();
    check("press_rise", 32'(bus.soc_rst), 32'd1);
    check("press_cause", 32'(bus.rst_cause), 32'd1);
    check("press_cnt", 32'(bus.rst_cnt), 32'd1);
    for (int i = 0; i < 13; i++) begin
      tick(); check("press_held", 32'(bus.soc_rst), 32'd1);
    end
    bus.btn_i = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick(); check("release_hold", 32'(bus.soc_rst), 32'd1);
    end
    tick();
    check("release_fall", 32'(bus.soc_rst), 32'd0);
    check("release_cause", 32'(bus.rst_cause), 32'd1);
    check("release_cnt", 32'(bus.rst_cnt), 32'd1);
    repeat (3) tick();

    // SW reset, second request during HOLD ignored
    bus.sw_req = 1'b1;
    tick();
    bus.sw_req = 1'b0;
    check("sw_rise", 32'(bus.soc_rst), 32'd1);
    check("sw_cause", 32'(bus.rst_cause), 32'd2);
    check("sw_cnt", 32'(bus.rst_cnt), 32'd2);
    tick();
    check("sw_hold2", 32'(bus.soc_rst), 32'd1);
    bus.sw_req = 1'b1;
    tick();
    bus.sw_req = 1'b0;
    check("sw_hold3", 32'(bus.soc_rst), 32'd1);
    check("sw_ign_cnt", 32'(bus.rst_cnt), 32'd2);
    tick();
    check("sw_fall", 32'(bus.soc_rst), 32'd0);
    check("sw_ign_cnt2", 32'(bus.rst_cnt), 32'd2);
    check("sw_ign_cause", 32'(bus.rst_cause), 32'd2);
    repeat (2) tick();

    // Simultaneous press flip and sw_req: button wins
    bus.btn_i = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(); check("sim_lat", 32'(bus.soc_rst), 32'd0);
    end
    bus.sw_req = 1'b1;
    tick();
    bus.sw_req = 1'b0;
    check("sim_rise", 32'(bus.soc_rst), 32'd1);
    check("sim_cause", 32'(bus.rst_cause), 32'd1);
    check("sim_cnt", 32'(bus.rst_cnt), 32'd3);
    for (int i = 0; i < 5; i++) begin
      tick(); check("sim_wait_rel", 32'(bus.soc_rst), 32'd1);
    end
    check("sim_cnt_hold", 32'(bus.rst_cnt), 32'd3);

    // rst during WAIT_REL restarts POR
    rst = 1'b1;
    bus.btn_i = 1'b0;
    tick();
    check("mid_rst", 32'(bus.soc_rst), 32'd1);
    check("mid_cause", 32'(bus.rst_cause), 32'd0);
    check("mid_cnt", 32'(bus.rst_cnt), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick(); check("mid_por1", 32'(bus.soc_rst), 32'd1);
    tick(); check("mid_por2", 32'(bus.soc_rst), 32'd1);
    tick(); check("mid_por_fall", 32'(bus.soc_rst), 32'd0);
    repeat (2) tick();
    check("mid_por_quiet", 32'(bus.soc_rst), 32'd0);

    // 300 sw requests: count saturates at 0xFF
    exp_cnt = 8'd0;
    for (int i = 0; i < 300; i++) begin
      bus.sw_req = 1'b1;
      tick();
      bus.sw_req = 1'b0;
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      check("sat_cnt", 32'(bus.rst_cnt), 32'(exp_cnt));
      repeat (4) tick();
    end
    check("sat_final", 32'(bus.rst_cnt), 32'hFF);
    check("sat_cause", 32'(bus.rst_cause), 32'd2);
    check("sat_run", 32'(bus.soc_rst), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
